// File: rtl/ExceptStruct.sv
// ExceptStruct: exception encodings and the packed exception record shared
// by the front-end stages.
//
// Contents:
//   EXC_W         width of the epc / ecause / etval fields
//   ECALL/EBREAK  fixed 32-bit encodings of the environment instructions
//   cause codes   BREAKPOINT, ILLEAGAL_INST, U/S/H/M_CALL
//   ExceptPack    {except, epc, ecause, etval}
package ExceptStruct;

  localparam int EXC_W = 64;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  localparam logic [EXC_W-1:0] ILLEAGAL_INST = EXC_W'(2);
  localparam logic [EXC_W-1:0] BREAKPOINT    = EXC_W'(3);
  localparam logic [EXC_W-1:0] U_CALL        = EXC_W'(8);
  localparam logic [EXC_W-1:0] S_CALL        = EXC_W'(9);
  localparam logic [EXC_W-1:0] H_CALL        = EXC_W'(10);
  localparam logic [EXC_W-1:0] M_CALL        = EXC_W'(11);

  typedef struct packed {
    logic             except;
    logic [EXC_W-1:0] epc;
    logic [EXC_W-1:0] ecause;
    logic [EXC_W-1:0] etval;
  } ExceptPack;

endpackage

// File: rtl/inst_examine_pkg.sv
// inst_examine_pkg: constants shared by the instruction examine stage.
//
// Contents:
//   OP_*              RV64I major opcodes accepted by the legality check
//   MRET/SRET/WFI     privileged instruction encodings
//   state_e           stage FSM states {RUN, HOLD}
//   isLegalOpcode()   membership test for the major-opcode table
package inst_examine_pkg;

  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_OP_IMM   = 7'h13;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_IMM_32   = 7'h1B;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_OP       = 7'h33;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_OP_32    = 7'h3B;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;

  localparam logic [31:0] MRET = 32'h3020_0073;
  localparam logic [31:0] SRET = 32'h1020_0073;
  localparam logic [31:0] WFI  = 32'h1050_0073;

  typedef enum logic {RUN, HOLD} state_e;

  function automatic logic isLegalOpcode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_AUIPC, OP_IMM_32, OP_STORE,
      OP_OP, OP_LUI, OP_OP_32, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_examine_stage_legal_check.sv
// inst_legal_check: combinational decode of one fetched instruction into
// legal / ecall / ebreak / illegal, plus the matching exception record.
//
// Ports:
//   pc_i       PC of the instruction
//   priv_i     current privilege (0 U, 1 S, 2 H, 3 M)
//   inst_i     instruction word
//   illegal_o  instruction is illegal at this privilege
//   except_o   {except, epc, ecause, etval} for this instruction
//
// Optional: define INST_EXAMINE_TVAL_EN to fill etval (instruction word for
// illegal, PC for ebreak); otherwise etval is always zero.
module inst_legal_check
  import inst_examine_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int CHECK_OPCODE = 1
) (
  input  logic [XLEN-1:0]         pc_i,
  input  logic [1:0]              priv_i,
  input  logic [31:0]             inst_i,
  output logic                    illegal_o,
  output ExceptStruct::ExceptPack except_o
);

  logic w_isEcall;
  logic w_isEbreak;
  logic w_badLow;
  logic w_badOpcode;
  logic w_badPriv;

  assign w_isEcall   = (inst_i == ExceptStruct::ECALL);
  assign w_isEbreak  = (inst_i == ExceptStruct::EBREAK);
  assign w_badLow    = (inst_i[1:0] != 2'b11);
  assign w_badOpcode = (CHECK_OPCODE != 0) && !isLegalOpcode(inst_i[6:0]);

  // mret needs M-mode; sret and wfi are only rejected from U-mode.
  assign w_badPriv = ((inst_i == MRET) && (priv_i != 2'd3)) ||
                     (((inst_i == SRET) || (inst_i == WFI)) && (priv_i == 2'd0));

  assign illegal_o = w_badLow || w_badOpcode || w_badPriv;

  // The three exception sources have disjoint encodings, so the if-chain
  // order never changes the outcome.
  always_comb begin
    except_o = '0;
    if (w_isEbreak) begin
      except_o.except = 1'b1;
      except_o.ecause = ExceptStruct::BREAKPOINT;
    end else if (w_isEcall) begin
      except_o.except = 1'b1;
      case (priv_i)
        2'd0:    except_o.ecause = ExceptStruct::U_CALL;
        2'd1:    except_o.ecause = ExceptStruct::S_CALL;
        2'd2:    except_o.ecause = ExceptStruct::H_CALL;
        default: except_o.ecause = ExceptStruct::M_CALL;
      endcase
    end else if (illegal_o) begin
      except_o.except = 1'b1;
      except_o.ecause = ExceptStruct::ILLEAGAL_INST;
    end
    if (except_o.except) begin
      except_o.epc = ExceptStruct::EXC_W'(pc_i);
    end
`ifdef INST_EXAMINE_TVAL_EN
    if (w_isEbreak) begin
      except_o.etval = ExceptStruct::EXC_W'(pc_i);
    end else if (illegal_o && !w_isEcall) begin
      except_o.etval = ExceptStruct::EXC_W'(inst_i);
    end
`endif
  end

endmodule

// File: rtl/inst_examine_stage.sv
// inst_examine_stage: registered examine stage between IF and ID. Classifies
// each instruction, registers it behind a valid/ready handshake, holds the
// front end after an excepting instruction until the trap is taken, and
// counts illegal instructions (saturating).
//
// Ports:
//   clk, rstn        clock; asynchronous active-low reset
//   pc_i, priv_i,    incoming PC, privilege, instruction
//   inst_i
//   valid_i/ready_o  upstream handshake
//   flush_i          pipeline flush (drops output entry, returns to RUN)
//   trap_taken_i     trap unit redirected; leaves HOLD
//   pc_o, inst_o,    registered PC, instruction and exception record
//   except_o
//   valid_o/ready_i  downstream handshake
//   pending_o        stage is in HOLD
//   illegal_cnt_o    saturating illegal-instruction count
//
// Optional: INST_EXAMINE_TVAL_EN enables etval generation.
module inst_examine_stage
  import inst_examine_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int CHECK_OPCODE = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [1:0]              priv_i,
  input  logic [31:0]             inst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  input  logic                    trap_taken_i,
  output logic [XLEN-1:0]         pc_o,
  output logic [31:0]             inst_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output ExceptStruct::ExceptPack except_o,
  output logic                    pending_o,
  output logic [CNT_W-1:0]        illegal_cnt_o
);

  state_e                  r_state;
  state_e                  w_stateNext;
  logic                    r_valid;
  logic [XLEN-1:0]         r_pc;
  logic [31:0]             r_inst;
  ExceptStruct::ExceptPack r_except;
  logic [CNT_W-1:0]        r_illegalCnt;

  logic                    w_illegal;
  ExceptStruct::ExceptPack w_except;
  logic                    w_ready;
  logic                    w_accept;

  inst_legal_check #(
    .XLEN         (XLEN),
    .CHECK_OPCODE (CHECK_OPCODE)
  ) u_legalCheck (
    .pc_i      (pc_i),
    .priv_i    (priv_i),
    .inst_i    (inst_i),
    .illegal_o (w_illegal),
    .except_o  (w_except)
  );

  // Accept only in RUN, never during a flush, and only when the output
  // slot is empty or is being drained this cycle.
  assign w_ready  = (r_state == RUN) && !flush_i && (!r_valid || ready_i);
  assign w_accept = valid_i && w_ready;

  // Output slot: flush empties it, accept refills it, a downstream take
  // without refill empties it, otherwise everything holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_inst   <= '0;
      r_except <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_pc     <= pc_i;
      r_inst   <= inst_i;
      r_except <= w_except;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Flush overrides everything and forces RUN; trap_taken only matters
  // while holding.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN:     if (w_accept && w_except.except) w_stateNext = HOLD;
      HOLD:    if (trap_taken_i) w_stateNext = RUN;
      default: w_stateNext = RUN;
    endcase
    if (flush_i) begin
      w_stateNext = RUN;
    end
  end

  // Saturating counter; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_illegalCnt <= '0;
    end else if (w_accept && w_illegal && (r_illegalCnt != {CNT_W{1'b1}})) begin
      r_illegalCnt <= r_illegalCnt + CNT_W'(1);
    end
  end

  assign ready_o       = w_ready;
  assign valid_o       = r_valid;
  assign pc_o          = r_pc;
  assign inst_o        = r_inst;
  assign except_o      = r_except;
  assign pending_o     = (r_state == HOLD);
  assign illegal_cnt_o = r_illegalCnt;

endmodule

// File: tb/tb_inst_examine_stage.sv
// tb_inst_examine_stage: directed checks of inst_examine_stage. A default
// instance covers decode, handshake, hold and flush; a CNT_W=2 instance
// covers counter saturation and asynchronous reset mid-stream.
module tb_inst_examine_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [63:0] pc;
  logic [1:0]  priv;
  logic [31:0] inst;
  logic        valid;
  logic        flush;
  logic        trap;
  logic        rdy;
  logic        readyO;
  logic [63:0] pcO;
  logic [31:0] instO;
  logic        validO;
  ExceptStruct::ExceptPack excO;
  logic        pendingO;
  logic [15:0] cntO;

  logic [63:0] sPc;
  logic [31:0] sInst;
  logic        sValid;
  logic        sTrap;
  logic        sReadyO;
  logic [63:0] sPcO;
  logic [31:0] sInstO;
  logic        sValidO;
  ExceptStruct::ExceptPack sExcO;
  logic        sPendingO;
  logic [1:0]  sCntO;

  int errors = 0;
  int checks = 0;

  inst_examine_stage u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .pc_i          (pc),
    .priv_i        (priv),
    .inst_i        (inst),
    .valid_i       (valid),
    .ready_o       (readyO),
    .flush_i       (flush),
    .trap_taken_i  (trap),
    .pc_o          (pcO),
    .inst_o        (instO),
    .valid_o       (validO),
    .ready_i       (rdy),
    .except_o      (excO),
    .pending_o     (pendingO),
    .illegal_cnt_o (cntO)
  );

  inst_examine_stage #(.CNT_W(2)) u_sat (
    .clk           (clk),
    .rstn          (rstn),
    .pc_i          (sPc),
    .priv_i        (2'd0),
    .inst_i        (sInst),
    .valid_i       (sValid),
    .ready_o       (sReadyO),
    .flush_i       (1'b0),
    .trap_taken_i  (sTrap),
    .pc_o          (sPcO),
    .inst_o        (sInstO),
    .valid_o       (sValidO),
    .ready_i       (1'b1),
    .except_o      (sExcO),
    .pending_o     (sPendingO),
    .illegal_cnt_o (sCntO)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseTrap();
    trap = 1'b1;
    tick();
    trap = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pc = '0; priv = '0; inst = '0; valid = 0; flush = 0; trap = 0; rdy = 1;
    sPc = '0; sInst = '0; sValid = 0; sTrap = 0;
    #2;
    checks++; if (validO !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", validO); end
    checks++; if (pcO !== 64'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", pcO); end
    checks++; if (instO !== 32'd0) begin errors++; $display("[TB] FAIL reset_inst: got %h want 0", instO); end
    checks++; if (excO !== '0) begin errors++; $display("[TB] FAIL reset_except: got %h want 0", excO); end
    checks++; if (pendingO !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending: got %0b want 0", pendingO); end
    checks++; if (cntO !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", cntO); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_legal();
    pc = 64'h1000; priv = 2'd0; inst = 32'h0000_0013; valid = 1; rdy = 1;
    #1;
    checks++; if (readyO !== 1'b1) begin errors++; $display("[TB] FAIL legal_ready_pre: got %0b want 1", readyO); end
    tick();
    valid = 0;
    checks++; if (validO !== 1'b1) begin errors++; $display("[TB] FAIL legal_valid: got %0b want 1", validO); end
    checks++; if (excO.except !== 1'b0) begin errors++; $display("[TB] FAIL legal_except: got %0b want 0", excO.except); end
    checks++; if (pcO !== 64'h1000) begin errors++; $display("[TB] FAIL legal_pc: got %h want 1000", pcO); end
    checks++; if (instO !== 32'h13) begin errors++; $display("[TB] FAIL legal_inst: got %h want 13", instO); end
    checks++; if (readyO !== 1'b1) begin errors++; $display("[TB] FAIL legal_ready: got %0b want 1", readyO); end
    checks++; if (cntO !== 16'd0) begin errors++; $display("[TB] FAIL legal_cnt: got %0d want 0", cntO); end
    tick();
    checks++; if (validO !== 1'b0) begin errors++; $display("[TB] FAIL legal_drain: got %0b want 0", validO); end
  endtask

  task automatic test_ecall();
    pc = 64'h8000_0000; priv = 2'd1; inst = 32'h0000_0073; valid = 1;
    tick();
    valid = 0;
    checks++; if (excO.except !== 1'b1) begin errors++; $display("[TB] FAIL ecall_except: got %0b want 1", excO.except); end
    checks++; if (excO.ecause !== 64'd9) begin errors++; $display("[TB] FAIL ecall_cause: got %0d want 9", excO.ecause); end
    checks++; if (excO.epc !== 64'h8000_0000) begin errors++; $display("[TB] FAIL ecall_epc: got %h want 80000000", excO.epc); end
    checks++; if (excO.etval !== 64'd0) begin errors++; $display("[TB] FAIL ecall_tval: got %h want 0", excO.etval); end
    checks++; if (pendingO !== 1'b1) begin errors++; $display("[TB] FAIL ecall_pending: got %0b want 1", pendingO); end
    checks++; if (readyO !== 1'b0) begin errors++; $display("[TB] FAIL ecall_ready: got %0b want 0", readyO); end
    tick();
    checks++; if (validO !== 1'b0) begin errors++; $display("[TB] FAIL ecall_drain: got %0b want 0", validO); end
    checks++; if (readyO !== 1'b0) begin errors++; $display("[TB] FAIL ecall_hold_ready: got %0b want 0", readyO); end
    pulseTrap();
    checks++; if (pendingO !== 1'b0) begin errors++; $display("[TB] FAIL ecall_release: got %0b want 0", pendingO); end
    checks++; if (readyO !== 1'b1) begin errors++; $display("[TB] FAIL ecall_ready_after: got %0b want 1", readyO); end
  endtask

  task automatic test_illegal();
    logic [63:0] expTval;
    pc = 64'h100; priv = 2'd1; inst = 32'h0; valid = 1;
    tick();
    valid = 0;
    checks++; if (excO.ecause !== 64'd2) begin errors++; $display("[TB] FAIL zero_cause: got %0d want 2", excO.ecause); end
    checks++; if (excO.etval !== 64'd0) begin errors++; $display("[TB] FAIL zero_tval: got %h want 0", excO.etval); end
    checks++; if (cntO !== 16'd1) begin errors++; $display("[TB] FAIL zero_cnt: got %0d want 1", cntO); end
    checks++; if (pendingO !== 1'b1) begin errors++; $display("[TB] FAIL zero_pending: got %0b want 1", pendingO); end
    pulseTrap();
    pc = 64'h104; inst = 32'h3020_0073; valid = 1;
    tick();
    valid = 0;
`ifdef INST_EXAMINE_TVAL_EN
    expTval = 64'h3020_0073;
`else
    expTval = 64'd0;
`endif
    checks++; if (excO.ecause !== 64'd2) begin errors++; $display("[TB] FAIL mret_cause: got %0d want 2", excO.ecause); end
    checks++; if (excO.etval !== expTval) begin errors++; $display("[TB] FAIL mret_tval: got %h want %h", excO.etval, expTval); end
    checks++; if (cntO !== 16'd2) begin errors++; $display("[TB] FAIL mret_cnt: got %0d want 2", cntO); end
    pulseTrap();
  endtask

  task automatic test_priv_checks();
    logic [31:0] vInst [5];
    logic [1:0]  vPriv [5];
    logic        vExc  [5];
    logic [63:0] vCause[5];
    vInst[0] = 32'h1020_0073; vPriv[0] = 2'd1; vExc[0] = 1'b0; vCause[0] = 64'd0;
    vInst[1] = 32'h1050_0073; vPriv[1] = 2'd0; vExc[1] = 1'b1; vCause[1] = 64'd2;
    vInst[2] = 32'h0000_002B; vPriv[2] = 2'd3; vExc[2] = 1'b1; vCause[2] = 64'd2;
    vInst[3] = 32'h0000_0073; vPriv[3] = 2'd3; vExc[3] = 1'b1; vCause[3] = 64'd11;
    vInst[4] = 32'h3020_0073; vPriv[4] = 2'd3; vExc[4] = 1'b0; vCause[4] = 64'd0;
    for (int i = 0; i < 5; i++) begin
      pc = 64'h200 + 64'(i * 4); inst = vInst[i]; priv = vPriv[i]; valid = 1;
      tick();
      valid = 0;
      checks++; if (excO.except !== vExc[i]) begin errors++; $display("[TB] FAIL priv%0d_except: got %0b want %0b", i, excO.except, vExc[i]); end
      checks++; if (excO.ecause !== vCause[i]) begin errors++; $display("[TB] FAIL priv%0d_cause: got %0d want %0d", i, excO.ecause, vCause[i]); end
      pulseTrap();
    end
    checks++; if (cntO !== 16'd4) begin errors++; $display("[TB] FAIL priv_cnt: got %0d want 4", cntO); end
  endtask

  task automatic test_back_to_back();
    priv = 2'd0; rdy = 1; valid = 1;
    pc = 64'h10; inst = 32'h0000_0033;
    tick();
    checks++; if (pcO !== 64'h10) begin errors++; $display("[TB] FAIL b2b_pc0: got %h want 10", pcO); end
    pc = 64'h14; inst = 32'h0000_0037;
    tick();
    valid = 0;
    checks++; if (pcO !== 64'h14 || validO !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pc1: got %h/%0b want 14/1", pcO, validO); end
    tick();
    checks++; if (validO !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %0b want 0", validO); end
  endtask

  task automatic test_stall();
    rdy = 0; priv = 2'd0; pc = 64'h2000; inst = 32'h0050_0093; valid = 1;
    tick();
    pc = 64'h3000; inst = 32'h0000_0013;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (validO !== 1'b1 || pcO !== 64'h2000 || instO !== 32'h0050_0093 || excO.except !== 1'b0)
        begin errors++; $display("[TB] FAIL stall%0d_hold: got v=%0b pc=%h inst=%h want 1/2000/00500093", i, validO, pcO, instO); end
      checks++; if (readyO !== 1'b0) begin errors++; $display("[TB] FAIL stall%0d_ready: got %0b want 0", i, readyO); end
    end
    valid = 0; rdy = 1;
    #1;
    checks++; if (readyO !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_release: got %0b want 1", readyO); end
    tick();
    checks++; if (validO !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain: got %0b want 0", validO); end
  endtask

  task automatic test_flush_hold();
    logic [63:0] expTval;
    rdy = 0; priv = 2'd3; pc = 64'h3000; inst = 32'h0010_0073; valid = 1;
    tick();
`ifdef INST_EXAMINE_TVAL_EN
    expTval = 64'h3000;
`else
    expTval = 64'd0;
`endif
    checks++; if (pendingO !== 1'b1) begin errors++; $display("[TB] FAIL ebreak_pending: got %0b want 1", pendingO); end
    checks++; if (excO.ecause !== 64'd3) begin errors++; $display("[TB] FAIL ebreak_cause: got %0d want 3", excO.ecause); end
    checks++; if (excO.etval !== expTval) begin errors++; $display("[TB] FAIL ebreak_tval: got %h want %h", excO.etval, expTval); end
    pc = 64'h4000; inst = 32'h0000_0013; flush = 1; trap = 1;
    #1;
    checks++; if (readyO !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %0b want 0", readyO); end
    tick();
    flush = 0; trap = 0; valid = 0;
    checks++; if (validO !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %0b want 0", validO); end
    checks++; if (pendingO !== 1'b0) begin errors++; $display("[TB] FAIL flush_pending: got %0b want 0", pendingO); end
    checks++; if (cntO !== 16'd4) begin errors++; $display("[TB] FAIL flush_cnt: got %0d want 4", cntO); end
    rdy = 1;
    tick();
    checks++; if (validO !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_accept: got %0b want 0", validO); end
  endtask

  task automatic test_saturation();
    int expCnt;
    for (int i = 0; i < 6; i++) begin
      sPc = 64'h40 + 64'(i); sInst = 32'h0; sValid = 1;
      tick();
      sValid = 0;
      expCnt = (i + 1 > 3) ? 3 : i + 1;
      checks++; if (sCntO !== 2'(expCnt)) begin errors++; $display("[TB] FAIL sat%0d_cnt: got %0d want %0d", i, sCntO, expCnt); end
      sTrap = 1;
      tick();
      sTrap = 0;
    end
    sPc = 64'h55; sInst = 32'h0000_0013; sValid = 1;
    tick();
    sValid = 0;
    checks++; if (sValidO !== 1'b1) begin errors++; $display("[TB] FAIL sat_inflight: got %0b want 1", sValidO); end
    #3;
    rstn = 1'b0;
    #1;
    checks++; if (sValidO !== 1'b0 || sPcO !== 64'd0 || sInstO !== 32'd0 || sExcO !== '0)
      begin errors++; $display("[TB] FAIL async_outputs: got v=%0b pc=%h inst=%h want zero", sValidO, sPcO, sInstO); end
    checks++; if (sCntO !== 2'd0 || sPendingO !== 1'b0) begin errors++; $display("[TB] FAIL async_cnt: got %0d/%0b want 0/0", sCntO, sPendingO); end
    checks++; if (cntO !== 16'd0) begin errors++; $display("[TB] FAIL async_main_cnt: got %0d want 0", cntO); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_legal();
    test_ecall();
    test_illegal();
    test_priv_checks();
    test_back_to_back();
    test_stall();
    test_flush_hold();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/inst_examine_stage.md
Name: inst_examine_stage

Overview:
- Registered, parametrised successor to the combinational instruction examiner.
- Sits between IF and ID.
- Classifies each fetched instruction: legal, ecall, ebreak, illegal, or privilege-violating system instruction.
- Registers the result with a valid/ready handshake and holds the front end after an excepting instruction until the trap is taken.
- Keeps a saturating illegal-instruction counter.

Parameters:
- XLEN, 64, width of PC and except fields.
- CHECK_OPCODE, 1: 1 = full RV64I major-opcode legality check; 0 = only inst[1:0]==2'b11 check.
- CNT_W, 16, width of illegal-instruction counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; asynchronous, active-low
- pc_i  in  XLEN  PC of incoming instruction
- priv_i  in  2  current privilege (0 U, 1 S, 2 H, 3 M)
- inst_i  in  32  incoming instruction
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- flush_i  in  1  pipeline flush
- trap_taken_i  in  1  trap unit has redirected; release hold
- pc_o  out  XLEN  registered PC
- inst_o  out  32  registered instruction
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- except_o  out  ExceptStruct::ExceptPack  registered except/epc/ecause/etval
- pending_o  out  1  state==HOLD
- illegal_cnt_o  out  CNT_W  saturating illegal count

Behaviour:
- Reset (rstn low, async): valid_o=0, pc_o=0, inst_o=0, except_o all-zero, state RUN, illegal_cnt_o=0.
- Decode (combinational):
  - illegal if inst[1:0]!=2'b11.
  - If CHECK_OPCODE=1, also illegal if inst[6:0] is not one of 03,0F,13,17,1B,23,33,37,3B,63,67,6F,73 (hex).
  - mret (0x30200073) illegal unless priv_i==3.
  - sret (0x10200073) and wfi (0x10500073) illegal when priv_i==0.
- Cause and etval:
  - ecause: ebreak → BREAKPOINT (3); ecall → U/S/H/M_CALL (8/9/10/11) indexed by priv_i; illegal → ILLEAGAL_INST (2); otherwise 0.
  - Encodings are exclusive, so no priority conflict.
  - except=1 for any of these cases; epc=pc_i.
- Handshake:
  - ready_o = (state==RUN) & !flush_i & (!valid_o | ready_i).
  - Accept = valid_i & ready_o. On accept, all output registers load next cycle (latency 1) and valid_o=1.
  - If valid_o & ready_i & no accept: valid_o←0.
  - valid_o & !ready_i: every output holds stable.
- FSM:
  - RUN → HOLD on accepting an instruction with except=1.
  - HOLD → RUN on trap_taken_i | flush_i.
  - In HOLD, ready_o=0. The excepting entry still drains downstream normally.
  - trap_taken_i in RUN is ignored.
- Flush: flush_i=1 → next cycle valid_o=0 and state RUN; no accept that cycle. Flush has priority over trap_taken_i and over accept. Other output fields are don't-care once valid_o=0.
- Counter: increments by 1 on accept of an illegal instruction; saturates at all-ones; not cleared by flush.
- Async reset mid-transaction: immediate return to reset values; an in-flight entry is dropped.

Optional Feature:
- Macro: INST_EXAMINE_TVAL_EN.
- Defined: etval = {zero-ext, inst_i} for illegal, pc_i for ebreak, 0 otherwise.
- Undefined: etval is always 0. Saves XLEN flops of mux logic.

Decomposition:
- Opcode constants, MRET/SRET/WFI encodings, and the state enum {RUN, HOLD} go in a shared package, inst_examine_pkg.
- ECALL/EBREAK and cause codes stay in Define.vh / ExceptStruct.
- Natural sub-module: inst_legal_check, the combinational decode/cause generation. The top holds the registers, FSM and counter.

Test Plan:
- Legal ADDI (0x00000013), priv 0, ready_i=1 → next cycle valid_o=1, except=0, ready_o stays 1, count 0.
- ECALL at pc 0x80000000, priv 1 → except=1, ecause=9, epc=0x80000000; pending_o=1, ready_o=0 until trap_taken_i pulse; one cycle later ready_o=1.
- inst 0x00000000, then MRET at priv 1 → both illegal, ecause=2. With INST_EXAMINE_TVAL_EN, etval=0x0 then 0x30200073. illegal_cnt_o=1 then 2 (trap_taken_i between them).
- ready_i held 0 for 5 cycles with valid_o=1 → pc_o/inst_o/except_o unchanged, ready_o=0; ready_i=1 → drains.
- flush_i while in HOLD with valid_o=1 → next cycle valid_o=0, pending_o=0, no accept in flush cycle.
- CNT_W=2, six illegal instructions → counter reads 3 and stays 3; assert rstn low mid-stream → all outputs zero asynchronously.
